// File: rtl/pipe_pkg.sv
// Shared pipeline-register types: stage state and occupancy encodings, reused
// by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      ST_BUSY: occ_of = OCC_BUSY;
      ST_FULL: occ_of = OCC_FULL;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline register with registered ready/valid,
// flush, and a saturating count of downstream stall cycles.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 71,
  parameter int CNT_W      = 16,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              ld_skid;

  assign out_data_o = main_q;

  always_comb begin
    in_fire      = in_valid_i & in_ready_o;
    out_fire     = out_valid_o & out_ready_i;
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_nxt  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          ld_skid   = 1'b1;
          state_nxt = ST_FULL;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_nxt    = ST_BUSY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any handshake in the same cycle; that cycle's input is dropped.
    if (flush_i) begin
      state_nxt    = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // Control: state, registered handshake flags, occupancy, stall counter
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= ST_EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      occ_o       <= OCC_EMPTY;
      stall_cnt_o <= '0;
    end else begin
      state       <= state_nxt;
      out_valid_o <= (state_nxt != ST_EMPTY);
      in_ready_o  <= (state_nxt != ST_FULL);
      occ_o       <= occ_of(state_nxt);
      if (out_valid_o && !out_ready_i && !flush_i)
        stall_cnt_o <= sat_inc(stall_cnt_o);
    end
  end

  // Payload: main feeds the output, skid catches the entry that arrives during a stall
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      if (CLEAR_DATA) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (ld_main_in)
        main_q <= in_data_i;
      else if (ld_main_skid)
        main_q <= skid_q;
      if (ld_skid)
        skid_q <= in_data_i;
    end
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 71, payload width in bits (covers 32+32+5+1+1 writeback bundle).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 The block SHALL have parameter CLEAR_DATA, default 1; when 1, payload registers are zeroed on reset and flush.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1, a synchronous, active-low reset.
REQ-006 The block SHALL have port flush_i, input, 1, which discards all held entries.
REQ-007 The block SHALL have port in_valid_i, input, 1, upstream entry present.
REQ-008 The block SHALL have port in_data_i, input, DATA_W, upstream payload.
REQ-009 The block SHALL have port in_ready_o, output, 1, block can accept; a registered signal.
REQ-010 The block SHALL have port out_valid_o, output, 1, downstream entry present.
REQ-011 The block SHALL have port out_data_o, output, DATA_W, downstream payload, driven from the main register only.
REQ-012 The block SHALL have port out_ready_i, input, 1, downstream accepts; 0 equals a stall.
REQ-013 The block SHALL have port occ_o, output, 2, number of held entries (0..2).
REQ-014 The block SHALL have port stall_cnt_o, output, CNT_W, the saturating count of stalled cycles.

Function
REQ-015 The block SHALL define in_fire = in_valid_i & in_ready_o and out_fire = out_valid_o & out_ready_i.
REQ-016 The block SHALL hold two storage registers: main (drives out_data_o) and skid.
REQ-017 The block SHALL implement states EMPTY (occ 0), BUSY (occ 1), FULL (occ 2); out_valid_o = (state != EMPTY), in_ready_o = (state != FULL), both registered.
REQ-018 EMPTY: in_fire -> main<=in_data_i, go BUSY; otherwise stay.
REQ-019 BUSY: in_fire & out_fire -> main<=in_data_i, stay BUSY; in_fire & !out_fire -> skid<=in_data_i, go FULL; !in_fire & out_fire -> go EMPTY; otherwise hold.
REQ-020 FULL: out_fire -> main<=skid, go BUSY; otherwise hold; no input is accepted (in_ready_o=0).
REQ-021 Latency SHALL be one cycle: data accepted in cycle N appears on out_data_o in cycle N+1 when the stage was EMPTY or drained in N.
REQ-022 Ordering SHALL be strict FIFO; no entry lost or duplicated; full throughput (one transfer per cycle) when out_ready_i stays 1.
REQ-023 flush_i=1 SHALL force EMPTY next cycle, overriding any simultaneous in_fire/out_fire; the input of that cycle is dropped; when CLEAR_DATA=1, main and skid are zeroed.
REQ-024 stall_cnt_o SHALL increment by 1 in each cycle with out_valid_o=1 & out_ready_i=0 & flush_i=0, saturating at 2^CNT_W-1 (no wrap).
REQ-025 stall_cnt_o SHALL be cleared only by reset; flush SHALL NOT clear it.
REQ-026 When CLEAR_DATA=0, the payload registers SHALL hold stale values after reset/flush; out_data_o is don't-care while out_valid_o=0.

Reset
REQ-027 When rst_i=0 at a rising edge, state SHALL become EMPTY: out_valid_o=0, in_ready_o=1, occ_o=0, stall_cnt_o=0, out_data_o=0 (if CLEAR_DATA=1).
REQ-028 Reset SHALL take priority over flush_i and all handshakes, including mid-transfer in state FULL; both entries are discarded.

Structure
REQ-029 The state enum (EMPTY/BUSY/FULL) and the occupancy encodings SHALL live in shared package pipe_pkg, for reuse by the IF/ID, ID/EX, EX/MEM and MEM/WB instances.
REQ-030 The block SHALL have no sub-module; the saturating counter is inline.

Verification
REQ-031 The bench SHALL cover streaming: out_ready_i=1, in_valid_i=1 with data 1,2,3,4 on consecutive cycles -> out 1,2,3,4 one cycle later, in_ready_o stays 1, stall_cnt_o=0.
REQ-032 The bench SHALL cover skid: send A,B with out_ready_i=0 -> occ_o=2, in_ready_o=0, out_data_o=A; raise out_ready_i -> A then B, occ 2->1->0.
REQ-033 The bench SHALL cover stall count: hold out_valid_o=1, out_ready_i=0 for 5 cycles -> stall_cnt_o=5; with CNT_W=2 and 5 cycles -> 3 (saturated).
REQ-034 The bench SHALL cover flush: in FULL, assert flush_i with in_valid_i=1, out_ready_i=1 -> next cycle occ_o=0, out_valid_o=0, out_data_o=0, no output transfer of the dropped input.
REQ-035 The bench SHALL cover reset mid-operation: rst_i=0 in FULL -> next edge occ_o=0, in_ready_o=1, stall_cnt_o=0; the first input after release appears alone.
REQ-036 The bench SHALL cover random scoreboard: random in_valid_i/out_ready_i/flush_i, 10k cycles -> output sequence equals input sequence minus flushed entries.
